// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue/writeback scheduler: op codes, result sources,
// misc-unit function selects and the per-op writeback latency.
package fpu_pkg;

  localparam int unsigned LAT_ADD_DEF = 3;
  localparam int unsigned LAT_MUL_DEF = 2;

  typedef enum logic [2:0] {
    FHALF = 3'd0,
    FNEG  = 3'd1,
    FABS  = 3'd2,
    FADD  = 3'd3,
    FSUB  = 3'd4,
    FMUL  = 3'd5
  } fop_t;

  typedef enum logic [1:0] {
    SRC_MISC = 2'd0,
    SRC_ADD  = 2'd1,
    SRC_MUL  = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    MISC_HALF = 2'd0,
    MISC_NEG  = 2'd1,
    MISC_ABS  = 2'd2
  } misc_t;

  typedef struct packed {
    logic [4:0] rd;
    src_t       src;
  } tag_t;

  function automatic logic is_valid_op(logic [2:0] op);
    return op <= 3'd5;
  endfunction

  function automatic int unsigned lat_of(fop_t op,
                                         int unsigned lat_add = LAT_ADD_DEF,
                                         int unsigned lat_mul = LAT_MUL_DEF);
    case (op)
      FADD, FSUB: return lat_add;
      FMUL:       return lat_mul;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_wb_resv.sv
// Result-bus reservation shift register with a lockstep tag pipeline.
// Slot i holds the op that writes back i-1 cycles from now; slot 1 is on the bus.
module fpu_wb_resv
  import fpu_pkg::*;
#(
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [D:1]   set_mask,
  input  tag_t         set_tag,
  output logic [D:1]   occ_q,
  output logic [D:1]   occ_sh,
  output logic         enter_valid,
  output tag_t         enter_tag
);

  logic [D:1] occ_d;
  tag_t       tag_sh [1:D];
  tag_t       tag_d  [1:D];
  tag_t       tag_q  [2:D];

  // Shift happens before the new reservation is merged, so a slot freed this
  // cycle can be claimed by the op accepted in the same cycle.
  always_comb begin
    occ_sh     = {1'b0, occ_q[D:2]};
    occ_d      = occ_sh | set_mask;
    tag_sh[D]  = '0;
    for (int unsigned i = 1; i < D; i++) begin
      tag_sh[i] = tag_q[i+1];
    end
    for (int unsigned i = 1; i <= D; i++) begin
      tag_d[i] = set_mask[i] ? set_tag : tag_sh[i];
    end
    enter_valid = occ_d[1];
    enter_tag   = tag_d[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      for (int unsigned i = 2; i <= D; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int unsigned i = 2; i <= D; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue/writeback scheduler: accepts one op per cycle, dispatches it to the
// misc/fadd/fmul unit and reserves the single writeback slot it will use.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD = LAT_ADD_DEF,
  parameter int unsigned LAT_MUL = LAT_MUL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  misc_sel,
  output logic [31:0] misc_x,
  input  logic [31:0] misc_y,
  output logic        add_go,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_y,
  output logic        mul_go,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_y,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        idle
);

  localparam int unsigned D = ((LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL) + 1;

  fop_t        op;
  logic        op_ok;
  logic        is_add;
  logic        is_mul;
  logic        accept;
  int unsigned lat;
  logic [D:1]  cand;
  logic [D:1]  set_mask;
  logic [D:1]  occ_q;
  logic [D:1]  occ_sh;
  tag_t        set_tag;
  tag_t        enter_tag;
  logic        enter_valid;
  misc_t       misc_fn;
  logic [31:0] cap_y;
  logic [4:0]  wb_rd_d, wb_rd_q;
  logic [31:0] wb_data_d, wb_data_q;

  always_comb begin
    op     = fop_t'(req_op);
    op_ok  = is_valid_op(req_op);
    is_add = op_ok & ((op == FADD) | (op == FSUB));
    is_mul = op_ok & (op == FMUL);
    lat    = lat_of(op, LAT_ADD, LAT_MUL);
    for (int unsigned i = 1; i <= D; i++) begin
      cand[i] = (i == lat + 1);
    end
    // Invalid ops are swallowed without a slot, so they never stall.
    req_ready = !rst & !(op_ok & |(occ_sh & cand));
    accept    = req_valid & req_ready;
    set_mask  = (accept & op_ok) ? cand : '0;

    set_tag.rd  = req_rd;
    set_tag.src = is_add ? SRC_ADD : (is_mul ? SRC_MUL : SRC_MISC);

    case (op)
      FNEG:    misc_fn = MISC_NEG;
      FABS:    misc_fn = MISC_ABS;
      default: misc_fn = MISC_HALF;
    endcase
    misc_sel = misc_fn;
    misc_x   = req_a;
    add_go   = accept & is_add;
    add_a    = req_a;
    add_b    = {req_b[31] ^ (op == FSUB), req_b[30:0]};
    mul_go   = accept & is_mul;
    mul_a    = req_a;
    mul_b    = req_b;
  end

  fpu_wb_resv #(.D(D)) u_resv (
    .clk         (clk),
    .rst         (rst),
    .set_mask    (set_mask),
    .set_tag     (set_tag),
    .occ_q       (occ_q),
    .occ_sh      (occ_sh),
    .enter_valid (enter_valid),
    .enter_tag   (enter_tag)
  );

  always_comb begin
    case (enter_tag.src)
      SRC_ADD: cap_y = add_y;
      SRC_MUL: cap_y = mul_y;
      default: cap_y = misc_y;
    endcase
    wb_rd_d   = enter_valid ? enter_tag.rd : '0;
    wb_data_d = enter_valid ? cap_y : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Outputs are forced quiet during reset, before the flops have cleared.
  assign wb_valid = !rst & occ_q[1];
  assign wb_rd    = rst ? '0 : wb_rd_q;
  assign wb_data  = rst ? '0 : wb_data_q;
  assign idle     = rst | ~|occ_q;

endmodule
